// File: rtl/sdio_cmd_sniffer_pkg.sv
// Shared definitions for the SD CMD-line sniffer: frame lengths, CRC7
// polynomial, event flag bit positions, one-hot states and default masks.
package sdio_cmd_sniffer_pkg;

  localparam int CMD_LEN  = 48;
  localparam int LONG_LEN = 136;

  // x^7 + x^3 + 1, shifted-register form (x^7 term implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int FLG_RESP_PRESENT = 0;
  localparam int FLG_RESP_LONG    = 1;
  localparam int FLG_CMD_CRC      = 2;
  localparam int FLG_RESP_CRC     = 3;
  localparam int FLG_TIMEOUT      = 4;
  localparam int FLG_RESP_DIR     = 5;
  localparam int FLG_OVERRUN      = 6;

  localparam logic [63:0] DEF_LONG_RESP_MASK = 64'h0000_0000_0000_0604;
  localparam logic [63:0] DEF_NO_RESP_MASK   = 64'h0000_0000_0000_8011;
  localparam logic [63:0] DEF_NO_CRC_MASK    = 64'h0000_0200_0000_0020;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_CMD_BITS  = 5'b00010,
    ST_RESP_WAIT = 5'b00100,
    ST_RESP_BITS = 5'b01000,
    ST_DONE      = 5'b10000
  } state_e;

  // Clamp a wide cycle count into the 8-bit latency field.
  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, init 0. Clear wins over enable.
module sdio_crc7
  import sdio_cmd_sniffer_pkg::*;
(
  input  logic       sd_clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  // Next CRC value: clear, shift one bit in, or hold.
  always_comb begin
    crc_d = crc_q;
    fb    = din ^ crc_q[6];
    if (clr) begin
      crc_d = 7'd0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

  // CRC register.
  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) crc_q <= 7'd0;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdio_cmd_sniffer.sv
// Passive SD CMD-line sniffer: frames each host command and its response,
// checks CRC7 on both, measures response latency and emits one event
// record per transaction over valid/ready, flagging dropped records.
module sdio_cmd_sniffer
  import sdio_cmd_sniffer_pkg::*;
#(
  parameter int          MAX_RESP_LAT   = 64,
  parameter logic [63:0] LONG_RESP_MASK = DEF_LONG_RESP_MASK,
  parameter logic [63:0] NO_RESP_MASK   = DEF_NO_RESP_MASK,
  parameter logic [63:0] NO_CRC_MASK    = DEF_NO_CRC_MASK,
  parameter bit          CRC_CHECK      = 1'b1
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [5:0]   evt_cmd,
  output logic [31:0]  evt_arg,
  output logic [127:0] evt_resp,
  output logic [7:0]   evt_flags,
  output logic [7:0]   evt_lat,
  output logic [4:0]   status
);

  state_e         state_q, state_d;
  logic           cmd_q;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    lat_q, lat_d, lat_inc;
  logic [44:0]    cmd_sr_q, cmd_sr_d;   // command bits 2..46 once complete
  logic [127:0]   resp_sr_q, resp_sr_d; // last 128 response bits, start bit cleared in
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic [7:0]     rflags_q, rflags_d;
  logic [7:0]     rlat_q, rlat_d;
  logic           ovr_pend_q, ovr_pend_d;
  logic           evt_valid_q, evt_valid_d;
  logic [5:0]     evt_cmd_q, evt_cmd_d;
  logic [31:0]    evt_arg_q, evt_arg_d;
  logic [127:0]   evt_resp_q, evt_resp_d;
  logic [7:0]     evt_flags_q, evt_flags_d;
  logic [7:0]     evt_lat_q, evt_lat_d;
  logic [4:0]     status_q;

  logic           cmd_crc_clr, cmd_crc_en, resp_crc_clr, resp_crc_en;
  logic [6:0]     cmd_crc, resp_crc;
  logic           resp_long, resp_crc_skip;
  logic [7:0]     resp_last;

  sdio_crc7 u_cmd_crc (
    .sd_clk (sd_clk), .rst (rst), .clr (cmd_crc_clr), .en (cmd_crc_en),
    .din (cmd_q), .crc (cmd_crc)
  );

  sdio_crc7 u_resp_crc (
    .sd_clk (sd_clk), .rst (rst), .clr (resp_crc_clr), .en (resp_crc_en),
    .din (cmd_q), .crc (resp_crc)
  );

  // Next-state, capture datapath and event slot logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    lat_d        = lat_q;
    cmd_sr_d     = cmd_sr_q;
    resp_sr_d    = resp_sr_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    rflags_d     = rflags_q;
    rlat_d       = rlat_q;
    ovr_pend_d   = ovr_pend_q;
    evt_valid_d  = evt_valid_q;
    evt_cmd_d    = evt_cmd_q;
    evt_arg_d    = evt_arg_q;
    evt_resp_d   = evt_resp_q;
    evt_flags_d  = evt_flags_q;
    evt_lat_d    = evt_lat_q;
    cmd_crc_clr  = 1'b0;
    cmd_crc_en   = 1'b0;
    resp_crc_clr = 1'b0;
    resp_crc_en  = 1'b0;
    lat_inc       = lat_q + 16'd1;
    resp_long     = LONG_RESP_MASK[idx_q];
    resp_last     = resp_long ? 8'(LONG_LEN - 1) : 8'(CMD_LEN - 1);
    resp_crc_skip = NO_CRC_MASK[idx_q] || !CRC_CHECK;

    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The start bit is 0 and CRC init is 0, so feeding it is a no-op.
        cmd_crc_clr = 1'b1;
        if (!cmd_q) begin
          state_d   = ST_CMD_BITS;
          bit_cnt_d = 8'd1;
          cmd_sr_d  = '0;
          resp_sr_d = '0;
          rflags_d  = '0;
          rlat_d    = '0;
          lat_d     = '0;
        end
      end
      ST_CMD_BITS: begin
        cmd_sr_d   = {cmd_sr_q[43:0], cmd_q};
        bit_cnt_d  = bit_cnt_q + 8'd1;
        cmd_crc_en = (bit_cnt_q <= 8'd39);
        if (bit_cnt_q == 8'd1 && !cmd_q) begin
          state_d = ST_IDLE;            // not host-to-card, ignore
        end else if (bit_cnt_q == 8'(CMD_LEN - 1)) begin
          idx_d = cmd_sr_q[44:39];
          arg_d = cmd_sr_q[38:7];
          if (CRC_CHECK && (cmd_crc != cmd_sr_q[6:0])) rflags_d[FLG_CMD_CRC] = 1'b1;
          lat_d   = '0;
          state_d = NO_RESP_MASK[cmd_sr_q[44:39]] ? ST_DONE : ST_RESP_WAIT;
        end
      end
      ST_RESP_WAIT: begin
        resp_crc_clr = 1'b1;
        lat_d        = lat_inc;
        if (!cmd_q) begin
          state_d   = ST_RESP_BITS;
          bit_cnt_d = 8'd1;
          rlat_d    = sat8(lat_inc);
          rflags_d[FLG_RESP_LONG] = resp_long;
        end else if (lat_inc == 16'(MAX_RESP_LAT)) begin
          // No response: latency reports the full wait.
          rflags_d[FLG_TIMEOUT] = 1'b1;
          rlat_d  = sat8(lat_inc);
          state_d = ST_DONE;
        end
      end
      ST_RESP_BITS: begin
        resp_sr_d = {resp_sr_q[126:0], cmd_q};
        bit_cnt_d = bit_cnt_q + 8'd1;
        // Long responses restart the CRC at bit 8 (after the 111111 header).
        resp_crc_clr = resp_long && (bit_cnt_q < 8'd8);
        resp_crc_en  = resp_long ? (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127)
                                 : (bit_cnt_q <= 8'd39);
        if (bit_cnt_q == 8'd1 && cmd_q) rflags_d[FLG_RESP_DIR] = 1'b1;
        if (bit_cnt_q == resp_last) begin
          rflags_d[FLG_RESP_PRESENT] = 1'b1;
          if (!resp_crc_skip && (resp_crc != resp_sr_q[6:0])) rflags_d[FLG_RESP_CRC] = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!evt_valid_q || evt_ready) begin
          evt_valid_d = 1'b1;
          evt_cmd_d   = idx_q;
          evt_arg_d   = arg_q;
          evt_resp_d  = rflags_q[FLG_RESP_LONG] ? resp_sr_q : {96'd0, resp_sr_q[39:8]};
          evt_flags_d = rflags_q;
          evt_flags_d[FLG_OVERRUN] = ovr_pend_q;
          evt_lat_d   = rlat_q;
          ovr_pend_d  = 1'b0;
        end else begin
          ovr_pend_d  = 1'b1;           // record dropped, report on next delivered event
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 1'b1;
      bit_cnt_q   <= '0;
      lat_q       <= '0;
      cmd_sr_q    <= '0;
      resp_sr_q   <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      rflags_q    <= '0;
      rlat_q      <= '0;
      ovr_pend_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_cmd_q   <= '0;
      evt_arg_q   <= '0;
      evt_resp_q  <= '0;
      evt_flags_q <= '0;
      evt_lat_q   <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_i;
      bit_cnt_q   <= bit_cnt_d;
      lat_q       <= lat_d;
      cmd_sr_q    <= cmd_sr_d;
      resp_sr_q   <= resp_sr_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      rflags_q    <= rflags_d;
      rlat_q      <= rlat_d;
      ovr_pend_q  <= ovr_pend_d;
      evt_valid_q <= evt_valid_d;
      evt_cmd_q   <= evt_cmd_d;
      evt_arg_q   <= evt_arg_d;
      evt_resp_q  <= evt_resp_d;
      evt_flags_q <= evt_flags_d;
      evt_lat_q   <= evt_lat_d;
      status_q    <= state_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_cmd   = evt_cmd_q;
  assign evt_arg   = evt_arg_q;
  assign evt_resp  = evt_resp_q;
  assign evt_flags = evt_flags_q;
  assign evt_lat   = evt_lat_q;
  assign status    = status_q;

endmodule
